// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per add.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_adder: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_shifted;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  assign fa_s        = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c        = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign sum_shifted = {fa_s, sum_sr[WIDTH-1:1]};
  assign last_bit    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The visible result is updated only on the edge that consumes the MSB, so
  // sum/cout never show partial values mid-operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shifted;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= sum_shifted;
            cout <= fa_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // During the MSB cycle the carry flop holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      ovf <= carry ^ fa_c;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus randomized operands
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: reference result is plain integer addition; operands
  // are scrambled during SHIFT and an optional mid-SHIFT start is injected.
  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic icin, input bit poke);
    logic [W:0]   total;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    total    = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
    exp_sum  = total[W-1:0];
    exp_cout = total[W];
    exp_ovf  = (ia[W-1] == ib[W-1]) && (exp_sum[W-1] != ia[W-1]);

    start = 1'b1; a = ia; b = ib; cin = icin;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      checkOutput("busy_in_shift", {31'd0, busy}, 32'd1);
      checkOutput("no_done_in_shift", {31'd0, done}, 32'd0);
      checkOutput("sum_holds", {24'd0, sum}, {24'd0, last_sum});
      checkOutput("cout_holds", {31'd0, cout}, {31'd0, last_cout});
      if (poke && i == 2) begin
        start = 1'b1; a = 8'h55;
      end
      if (poke && i == 3) begin
        start = 1'b0;
      end
      tick();
    end
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
    checkOutput("sum", {24'd0, sum}, {24'd0, exp_sum});
    checkOutput("cout", {31'd0, cout}, {31'd0, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf) begin end
`endif
    last_sum  = exp_sum;
    last_cout = exp_cout;
    tick();
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
    checkOutput("sum_after_done", {24'd0, sum}, {24'd0, last_sum});
  endtask

  initial begin
    int  last_done;
    int  pulses;
    int  guard;
    bit  saw_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_sum", {24'd0, sum}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);

    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    // Abort mid-operation with reset.
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_sum", {24'd0, sum}, 32'd0);
    checkOutput("abort_cout", {31'd0, cout}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, saw_done}, 32'd0);
    last_sum = '0;
    last_cout = 1'b0;

    // start held high: back-to-back operations every WIDTH+2 cycles.
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    last_done = -1;
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (done) begin
        checkOutput("b2b_sum", {24'd0, sum}, 32'h30);
        checkOutput("b2b_cout", {31'd0, cout}, 32'd0);
        if (last_done >= 0) begin
          checkOutput("b2b_gap", cyc - last_done, W + 2);
        end
        last_done = cyc;
        pulses++;
      end
    end
    start = 1'b0;
    checkOutput("b2b_pulses", pulses, 3);
    guard = 0;
    while ((busy || done) && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("b2b_drain", {31'd0, busy | done}, 32'd0);
    last_sum = 8'h30;
    last_cout = 1'b0;

    applyStimulus(8'hA5, 8'h5B, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand and sum width in bits; legal range is 2..32.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add a, b and cin; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on the accepted start.
REQ-006 b  input  WIDTH  operand B, captured on the accepted start.
REQ-007 cin  input  1  carry-in, captured on the accepted start.
REQ-008 busy  output  1  high while the bit-serial addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the MSB.

Function
REQ-012 The datapath SHALL be one full-adder cell (sum bit = a^b^c; carry = ab | c(a^b)) with a carry flip-flop, processing one bit per cycle, LSB first.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE, with start=1 at an edge, the block SHALL load the a/b shift registers, load carry with cin, clear the bit counter and go to SHIFT.
REQ-015 In SHIFT, each edge SHALL shift a and b right by one, shift the new sum bit into the MSB of the internal sum register, update carry and increment the counter.
REQ-016 After exactly WIDTH SHIFT cycles the FSM SHALL go to DONE, copying the internal sum to sum and the final carry to cout on that same edge.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-019 Latency: start accepted at edge k SHALL give busy=1 for cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1.
REQ-020 start SHALL be ignored in SHIFT and DONE; a, b and cin changing during SHIFT SHALL NOT affect the result.
REQ-021 sum and cout SHALL hold the last completed result until the next DONE, and SHALL NOT show intermediate values.
REQ-022 start held high continuously SHALL give back-to-back operations, each accepted on the first IDLE cycle after DONE.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and clear sum, cout, busy, done, carry, counter and shift registers to 0; rst SHALL take priority over start.
REQ-024 Reset during SHIFT SHALL abort the operation with no done pulse, and sum/cout SHALL read 0.

Configuration
REQ-025 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add an output ovf (1 bit) that is registered alongside sum.
REQ-026 ovf SHALL equal the carry into the MSB XOR cout (two's-complement overflow), SHALL be reset to 0 and SHALL hold like sum.
REQ-027 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL NOT exist, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 After reset, start with a=0x0F, b=0x01, cin=0 -> busy for 8 cycles, then done in the 9th cycle after start, sum=0x10, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 start with a=0x03, b=0x04, then start pulsed with a=0x55 mid-SHIFT -> sum=0x07, and exactly one done pulse.
REQ-031 rst asserted 4 cycles into SHIFT -> next cycle busy=0, done=0, sum=0x00, cout=0, and no done pulse follows.
REQ-032 start held high for 30 cycles with a=0x10, b=0x20 -> done pulses exactly 10 cycles apart, each with sum=0x30.
REQ-033 With SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 -> ovf=1, sum=0x80; a=0x80, b=0x80 -> ovf=1, cout=1, sum=0x00; a=0x05, b=0x03 -> ovf=0.
